// File: rtl/mux9_rr_arbiter_if.sv
// Request/grant bundle between nine requesters and the round-robin arbiter
// that owns the 9:1 mux select.
interface mux9_rr_arbiter_if;
    logic [8:0] req;
    logic [8:0] gnt;
    logic [3:0] sel;
    logic       valid;
    logic [3:0] owner;

    // Requester side: raises requests, observes grant and select.
    modport master (
        output req,
        input  gnt,
        input  sel,
        input  valid,
        input  owner
    );

    // Arbiter side: samples requests, drives grant, select and ownership.
    modport slave (
        input  req,
        output gnt,
        output sel,
        output valid,
        output owner
    );
endinterface

// File: rtl/mux9_rr_arbiter.sv
// Round-robin arbiter for the shared 9:1 single-bit mux. Picks at most one
// owner per cycle, bounds each owner's burst to MAX_BURST cycles and drives
// the mux select together with a one-hot grant. All outputs are registered
// and change together on the same edge.
module mux9_rr_arbiter #(
    parameter int MAX_BURST = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux9_rr_arbiter_if.slave      bus
);

    localparam logic [3:0] BURST_MAX  = 4'(MAX_BURST);
    localparam logic [3:0] LAST_RESET = 4'd8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] owner_q;
    logic [3:0] owner_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [3:0] last;
    logic [3:0] last_nxt;
    logic [8:0] gnt_q;
    logic [8:0] gnt_nxt;
    logic [3:0] sel_q;
    logic [3:0] sel_nxt;
    logic       valid_nxt;

    logic       pick_found;
    logic [3:0] pick_idx;
    logic [4:0] pick;

    // Search starts just after the previous owner and wraps 8 -> 0, so the
    // previous owner is examined last and only wins when nobody else asks.
    function automatic logic [4:0] rr_pick(input logic [8:0] r,
                                           input logic [3:0] lst);
        logic [4:0] res;
        logic [3:0] idx;
        res = 5'd0;
        for (int k = 9; k >= 1; k--) begin
            idx = 4'((int'(lst) + k) % 9);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Owners 0..7 map straight onto the low select bits; owner 8 is the
    // ninth mux leg selected by the top bit alone.
    function automatic logic [3:0] sel_of(input logic [3:0] own);
        logic [3:0] s;
        if (own == 4'd8) begin
            s = 4'b1000;
        end else begin
            s = {1'b0, own[2:0]};
        end
        return s;
    endfunction

    assign pick       = rr_pick(bus.req, last);
    assign pick_found = pick[4];
    assign pick_idx   = pick[3:0];

    // State register: arbitration state plus the registered outputs so that
    // gnt, sel, owner and valid always move on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner_q <= 4'd0;
            cnt     <= 4'd0;
            last    <= LAST_RESET;
            gnt_q   <= 9'd0;
            sel_q   <= 4'd0;
        end else begin
            state   <= state_nxt;
            owner_q <= owner_nxt;
            cnt     <= cnt_nxt;
            last    <= last_nxt;
            gnt_q   <= gnt_nxt;
            sel_q   <= sel_nxt;
        end
    end

    // Next-state logic: keep the owner while it requests and has burst
    // budget left, otherwise rearbitrate in the same cycle (zero bubble).
    always_comb begin
        state_nxt = state;
        owner_nxt = owner_q;
        cnt_nxt   = cnt;
        last_nxt  = last;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = GRANT;
                    owner_nxt = pick_idx;
                    cnt_nxt   = 4'd1;
                    last_nxt  = pick_idx;
                end
            end
            GRANT: begin
                if (bus.req[owner_q] && (cnt < BURST_MAX)) begin
                    cnt_nxt = cnt + 4'd1;
                end else if (pick_found) begin
                    // Covers release with handover and burst expiry; on
                    // expiry a lone requester wins again with a fresh count.
                    owner_nxt = pick_idx;
                    cnt_nxt   = 4'd1;
                    last_nxt  = pick_idx;
                end else begin
                    state_nxt = IDLE;
                    owner_nxt = 4'd0;
                    cnt_nxt   = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = 4'd0;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Output decode of the next state, captured by the state register.
    always_comb begin
        gnt_nxt   = 9'd0;
        sel_nxt   = 4'd0;
        valid_nxt = 1'b0;
        if (state_nxt == GRANT) begin
            valid_nxt = 1'b1;
            gnt_nxt   = 9'd1 << owner_nxt;
            sel_nxt   = sel_of(owner_nxt);
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.owner = owner_q;
    assign bus.valid = (state == GRANT);

endmodule

// File: tb/tb_mux9_rr_arbiter.sv
// Directed bench for mux9_rr_arbiter with a burst limit of 4.
module tb_mux9_rr_arbiter;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    mux9_rr_arbiter_if bus ();

    mux9_rr_arbiter #(
        .MAX_BURST (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] eg,
                       input logic [3:0] es, input logic ev,
                       input logic [3:0] eo);
        logic [17:0] obs;
        logic [17:0] exp;
        obs = {bus.gnt, bus.sel, bus.valid, bus.owner};
        exp = {eg, es, ev, eo};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed gnt=%h sel=%b valid=%b owner=%0d, expected gnt=%h sel=%b valid=%b owner=%0d",
                   tag, bus.gnt, bus.sel, bus.valid, bus.owner, eg, es, ev, eo);
        end
    endtask

    initial begin
        logic [8:0] allreq;
        logic [3:0] o;
        logic [3:0] burst_seq [9];
        n_assert = 0;
        n_fail   = 0;
        allreq   = 9'h1FF;
        burst_seq = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0};

        // Reset for two cycles
        rst_n   = 1'b0;
        bus.req = 9'h000;
        step();
        step();
        chk("reset", 9'h000, 4'b0000, 1'b0, 4'd0);

        // Single requester 2
        rst_n   = 1'b1;
        bus.req = 9'h004;
        step();
        chk("single_req2", 9'h004, 4'b0010, 1'b1, 4'd2);

        // Reset mid-grant drops it on that edge
        rst_n = 1'b0;
        step();
        chk("reset_mid_grant", 9'h000, 4'b0000, 1'b0, 4'd0);

        // Requester 8 encoding
        rst_n   = 1'b1;
        bus.req = 9'h100;
        step();
        chk("req8_encoding", 9'h100, 4'b1000, 1'b1, 4'd8);

        bus.req = 9'h000;
        step();
        chk("idle_after_req8", 9'h000, 4'b0000, 1'b0, 4'd0);

        // Round robin: all request, each owner drops after one granted cycle
        bus.req = allreq;
        step();
        chk("rr_first", 9'h001, 4'b0000, 1'b1, 4'd0);
        for (int i = 0; i < 9; i++) begin
            bus.req = allreq & ~(9'd1 << i);
            step();
            o = 4'((i + 1) % 9);
            chk($sformatf("rr_rotate_%0d", i), 9'd1 << o,
                (o == 4'd8) ? 4'b1000 : o, 1'b1, o);
        end

        // Burst limit with two constant requesters, fresh round-robin pointer
        rst_n   = 1'b0;
        bus.req = 9'h000;
        step();
        rst_n   = 1'b1;
        bus.req = 9'h003;
        for (int i = 0; i < 9; i++) begin
            step();
            o = burst_seq[i];
            chk($sformatf("burst_%0d", i), 9'd1 << o, o, 1'b1, o);
        end

        // Lone requester keeps the grant across burst expiry
        bus.req = 9'h001;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("lone_%0d", i), 9'h001, 4'b0000, 1'b1, 4'd0);
        end

        // Zero-bubble handover from owner 3 to owner 5
        bus.req = 9'h000;
        step();
        chk("idle_before_handover", 9'h000, 4'b0000, 1'b0, 4'd0);
        bus.req = 9'h008;
        step();
        chk("owner3_grant", 9'h008, 4'b0011, 1'b1, 4'd3);
        bus.req = 9'h028;
        step();
        chk("owner3_hold", 9'h008, 4'b0011, 1'b1, 4'd3);
        bus.req = 9'h020;
        step();
        chk("handover_to5", 9'h020, 4'b0101, 1'b1, 4'd5);

        // Idle return, then a fresh request
        bus.req = 9'h000;
        step();
        chk("idle_return", 9'h000, 4'b0000, 1'b0, 4'd0);
        bus.req = 9'h010;
        step();
        chk("regrant_req4", 9'h010, 4'b0100, 1'b1, 4'd4);

        // Reset during an active grant
        rst_n = 1'b0;
        step();
        chk("reset_final", 9'h000, 4'b0000, 1'b0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
